// File: rtl/cosim_fifo_pkg.sv
// Shared sizing helpers and constants for the cosim endpoint output FIFO.
package cosim_fifo_pkg;

  localparam int MSG_COUNT_BITS = 32;
  localparam int MAX_DEPTH      = 256;

  // Pointer width for a power-of-two depth; never narrower than one bit.
  function automatic int ptr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy needs one more bit than the pointer so that 0..DEPTH fits.
  function automatic int cnt_bits(input int depth);
    return ptr_bits(depth) + 1;
  endfunction

  typedef logic [cnt_bits(MAX_DEPTH)-1:0] count_max_t;
  typedef logic [MSG_COUNT_BITS-1:0]      msg_count_t;

endpackage

// File: rtl/cosim_fifo_mem.sv
// DEPTH x W register file: one enabled write port, asynchronous read port.
module cosim_fifo_mem
  import cosim_fifo_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [ptr_bits(DEPTH)-1:0] waddr,
  input  logic [W-1:0]               wdata,
  input  logic [ptr_bits(DEPTH)-1:0] raddr,
  output logic [W-1:0]               rdata
);

  logic [DEPTH-1:0][W-1:0] mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cosim_ep_out_fifo.sv
// Elastic FWFT FIFO behind the cosim endpoint DataOut channel, with flush,
// registered occupancy/almost-full flags and a delivered-message counter.
module cosim_ep_out_fifo
  import cosim_fifo_pkg::*;
#(
  parameter int TYPE_SIZE_BITS     = 32,
  parameter int DEPTH              = 8,
  parameter int ALMOST_FULL_THRESH = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         DataInValid,
  output logic                         DataInReady,
  input  logic [TYPE_SIZE_BITS-1:0]    DataIn,
  output logic                         DataOutValid,
  input  logic                         DataOutReady,
  output logic [TYPE_SIZE_BITS-1:0]    DataOut,
  input  logic                         Flush,
  output logic [$clog2(DEPTH):0]       Count,
  output logic                         AlmostFull,
  output logic [MSG_COUNT_BITS-1:0]    MsgCount
);

  localparam int PW = ptr_bits(DEPTH);
  localparam int CW = cnt_bits(DEPTH);
  typedef logic [CW-1:0] count_t;

  logic [PW-1:0] wr_ptr, rd_ptr;
  count_t        count, count_nxt;
  logic          ready_q, af_q;
  msg_count_t    msg_cnt;
  logic          push, pop;

  // Flush gates ready combinationally so no upstream handshake lands in a
  // cycle whose contents are about to be discarded.
  assign DataInReady  = ready_q & ~Flush;
  assign DataOutValid = (count != '0);
  assign push         = DataInValid & DataInReady;
  assign pop          = DataOutValid & DataOutReady & ~Flush;

  always_comb begin
    count_nxt = count;
    if (Flush) begin
      count_nxt = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_nxt = count + count_t'(1);
        2'b01:   count_nxt = count - count_t'(1);
        default: count_nxt = count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b0;
      af_q    <= 1'b0;
      msg_cnt <= '0;
    end else begin
      if (Flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
      if (pop) msg_cnt <= msg_cnt + MSG_COUNT_BITS'(1);
      count   <= count_nxt;
      ready_q <= (count_nxt < count_t'(DEPTH));
      af_q    <= (count_nxt >= count_t'(ALMOST_FULL_THRESH));
    end
  end

  cosim_fifo_mem #(
    .W     (TYPE_SIZE_BITS),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (DataIn),
    .raddr (rd_ptr),
    .rdata (DataOut)
  );

  assign Count      = count;
  assign AlmostFull = af_q;
  assign MsgCount   = msg_cnt;

endmodule

// File: tb/tb_cosim_ep_out_fifo.sv
// Random + directed bench for cosim_ep_out_fifo against a queue-based model.
module tb_cosim_ep_out_fifo;

  localparam int W  = 32;
  localparam int D  = 8;
  localparam int AF = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          DataInValid = 1'b0;
  logic          DataInReady;
  logic [W-1:0]  DataIn = '0;
  logic          DataOutValid;
  logic          DataOutReady = 1'b0;
  logic [W-1:0]  DataOut;
  logic          Flush = 1'b0;
  logic [3:0]    Count;
  logic          AlmostFull;
  logic [31:0]   MsgCount;

  cosim_ep_out_fifo #(
    .TYPE_SIZE_BITS     (W),
    .DEPTH              (D),
    .ALMOST_FULL_THRESH (AF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .DataInValid  (DataInValid),
    .DataInReady  (DataInReady),
    .DataIn       (DataIn),
    .DataOutValid (DataOutValid),
    .DataOutReady (DataOutReady),
    .DataOut      (DataOut),
    .Flush        (Flush),
    .Count        (Count),
    .AlmostFull   (AlmostFull),
    .MsgCount     (MsgCount)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  // Reference model: queue of held messages, the ready the upstream should
  // see next cycle, and the delivered count.
  logic [W-1:0] q[$];
  bit           m_rdy = 1'b0;
  logic [31:0]  m_msg = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outs();
    chk("ready", 32'(DataInReady), 32'(m_rdy && !Flush));
    chk("valid", 32'(DataOutValid), 32'(q.size() != 0));
    if (q.size() != 0) chk("data", DataOut, q[0]);
    chk("count", 32'(Count), 32'(q.size()));
    chk("afull", 32'(AlmostFull), 32'(q.size() >= AF));
    chk("msgcnt", MsgCount, m_msg);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, 32'(DataInReady), 32'd0);
    chk({tag, "_valid"}, 32'(DataOutValid), 32'd0);
    chk({tag, "_data"},  DataOut, 32'd0);
    chk({tag, "_count"}, 32'(Count), 32'd0);
    chk({tag, "_afull"}, 32'(AlmostFull), 32'd0);
    chk({tag, "_msg"},   MsgCount, 32'd0);
  endtask

  // One clock: drive at negedge, check just after, advance the model.
  task automatic cycle(input bit v, input logic [W-1:0] d, input bit r, input bit f);
    bit push, pop;
    @(negedge clk);
    DataInValid = v; DataIn = d; DataOutReady = r; Flush = f;
    #1;
    check_outs();
    push = v && m_rdy && !f;
    pop  = (q.size() != 0) && r && !f;
    if (f) q.delete();
    else begin
      if (pop) begin
        void'(q.pop_front());
        m_msg++;
      end
      if (push) q.push_back(d);
    end
    m_rdy = (q.size() < D);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
    DataInValid = 1'b0; DataOutReady = 1'b0; Flush = 1'b0;
    #1;
    check_outs();
    m_rdy = 1'b1;
  endtask

  initial begin
    #1;
    check_zero("reset");
    release_rst();

    // Single push, consumer stalled
    cycle(1, 32'hA5A5A5A5, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);

    // Fill to full, then hold a 9th value that must not be taken
    for (int i = 1; i <= 8; i++) cycle(1, W'(i), 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 32'd9, 0, 0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);

    // Steady stream at occupancy 2 across pointer wraps
    cycle(1, 32'h100, 0, 0);
    cycle(1, 32'h101, 0, 0);
    for (int i = 0; i < 20; i++) cycle(1, 32'h200 + W'(i), 1, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0);

    // Flush at occupancy 5 with a pending upstream message
    for (int i = 0; i < 5; i++) cycle(1, 32'h300 + W'(i), 0, 0);
    cycle(1, 32'h3FF, 0, 1);
    cycle(0, 0, 0, 0);
    cycle(1, 32'h400, 0, 0);
    cycle(0, 0, 1, 0);

    // Asynchronous reset mid-burst at occupancy 3
    for (int i = 0; i < 3; i++) cycle(1, 32'h500 + W'(i), 0, 0);
    @(negedge clk);
    DataInValid = 1'b1; DataIn = 32'h5FF; DataOutReady = 1'b0;
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    q.delete(); m_rdy = 1'b0; m_msg = '0;
    @(posedge clk);
    #1 check_zero("rst_held");
    release_rst();
    for (int i = 0; i < 4; i++) cycle(1, 32'h600 + W'(i), 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0);

    // Randomized traffic with occasional flush
    for (int i = 0; i < 600; i++)
      cycle(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 59) == 0));
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 2) == 0), $urandom, ($urandom_range(0, 3) != 0), 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
